// File: rtl/mw_adder_pkg.sv
// Shared definitions for the multi-word sequential adder: limb width, FSM
// state encoding and the limb-index width helper.
package mw_adder_pkg;

   localparam int LIMB_W = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic int idx_width(input int words);
      return $clog2(words);
   endfunction

endpackage

// File: rtl/mw_seq_adder_if.sv
// Operand/result handshake bundle for mw_seq_adder; the adder is the slave,
// the upstream/downstream logic (or the bench) is the master.
interface mw_seq_adder_if #(
   parameter int WORDS = 4
);
   import mw_adder_pkg::*;

   localparam int W = LIMB_W * WORDS;

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          cout;
   logic          overflow;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, overflow
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, overflow
   );

endinterface

// File: rtl/csa_16bit.sv
// 16-bit carry-select adder: four 4-bit blocks, each precomputing both carry
// cases so the block carry only drives a select.
module csa_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   localparam int BLK = 4;
   localparam int NB  = 4;

   logic [NB:0] c;

   assign c[0] = cin;

   for (genvar g = 0; g < NB; g++) begin : g_blk
      logic [BLK:0] r0;
      logic [BLK:0] r1;

      assign r0 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
      assign r1 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]} + 5'd1;

      assign sum[g*BLK +: BLK] = c[g] ? r1[BLK-1:0] : r0[BLK-1:0];
      assign c[g+1]            = c[g] ? r1[BLK]     : r0[BLK];
   end

   assign cout = c[NB];

endmodule

// File: rtl/mw_seq_adder.sv
// Multi-word adder/subtractor: buffers one operand pair and streams it limb by
// limb through a single csa_16bit with a registered inter-limb carry.
//
// state  | meaning
// S_IDLE | ready for an operand pair (in_ready=1)
// S_RUN  | one limb per cycle through the 16-bit adder
// S_DONE | result held on sum/cout/overflow (out_valid=1)
module mw_seq_adder
   import mw_adder_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   mw_seq_adder_if.slave    bus
);

   localparam int W     = LIMB_W * WORDS;
   localparam int IDX_W = idx_width(WORDS);

   state_t             state_q;
   state_t             state_d;
   logic [W-1:0]       op_a;
   logic [W-1:0]       op_b;
   logic [W-1:0]       res;
   logic               carry;
   logic [IDX_W-1:0]   idx;
   logic               cout_q;
   logic               ovf_q;

   logic               accept;
   logic               last;
   logic [LIMB_W-1:0]  limb_a;
   logic [LIMB_W-1:0]  limb_b;
   logic [LIMB_W-1:0]  limb_sum;
   logic               limb_cout;

   always_comb begin
      limb_a = '0;
      limb_b = '0;
      for (int i = 0; i < WORDS; i++) begin
         if (idx == IDX_W'(i)) begin
            limb_a = op_a[i*LIMB_W +: LIMB_W];
            limb_b = op_b[i*LIMB_W +: LIMB_W];
         end
      end
   end

   csa_16bit u_csa (
      .a    (limb_a),
      .b    (limb_b),
      .cin  (carry),
      .sum  (limb_sum),
      .cout (limb_cout)
   );

   assign last = (idx == IDX_W'(WORDS - 1));

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a   <= '0;
         op_b   <= '0;
         res    <= '0;
         carry  <= 1'b0;
         idx    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         if (accept) begin
            op_a  <= bus.a;
            op_b  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub | bus.cin;
            idx   <= '0;
         end
         if (state_q == S_RUN) begin
            for (int i = 0; i < WORDS; i++) begin
               if (idx == IDX_W'(i)) begin
                  res[i*LIMB_W +: LIMB_W] <= limb_sum;
               end
            end
            carry <= limb_cout;
            // Index holds on the top limb; it is only cleared by the next accept.
            if (last) begin
               cout_q <= limb_cout;
               ovf_q  <= (op_a[W-1] == op_b[W-1]) && (limb_sum[LIMB_W-1] != op_a[W-1]);
            end else begin
               idx <= idx + IDX_W'(1);
            end
         end
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.sum       = res;
   assign bus.cout      = cout_q;
   assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_mw_seq_adder.sv
// Directed bench for mw_seq_adder (WORDS=4): hand-computed vectors, latency,
// backpressure and mid-operation reset.
module tb_mw_seq_adder;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   mw_seq_adder_if #(.WORDS(4)) bus ();

   mw_seq_adder #(.WORDS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at the negedge of the first cycle after the accept edge.
   task automatic wait_done(output int lat);
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the first negedge with out_valid.
   task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub, output int lat);
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      bus.sub      = sub;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_done(lat);
   endtask

   task automatic release_result();
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic [63:0] s,
                               input logic c, input logic o);
      chk64({tag, "_sum"}, bus.sum, s);
      chk1({tag, "_cout"}, bus.cout, c);
      chk1({tag, "_ovf"}, bus.overflow, o);
   endtask

   initial begin
      int lat;
      logic [63:0] held_sum;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk1("rst_in_ready", bus.in_ready, 1'b1);
      chk1("rst_out_valid", bus.out_valid, 1'b0);
      check_result("rst", 64'h0, 1'b0, 1'b0);

      // Carry crossing limb 0 -> limb 1, plus latency
      do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, lat);
      chk_int("carry_latency", lat, 5);
      chk1("carry_in_ready", bus.in_ready, 1'b0);
      check_result("carry", 64'h0000_0000_0001_0000, 1'b0, 1'b0);
      release_result();
      chk1("carry_back_idle", bus.in_ready, 1'b1);
      chk1("carry_out_valid_low", bus.out_valid, 1'b0);

      do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, lat);
      check_result("wrap", 64'h0, 1'b1, 1'b0);
      release_result();

      do_op(64'h5, 64'h7, 1'b0, 1'b1, lat);
      check_result("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      release_result();

      // cin=1 must be ignored in subtract mode
      do_op(64'h7, 64'h5, 1'b1, 1'b1, lat);
      check_result("sub_noborrow", 64'h2, 1'b1, 1'b0);
      release_result();

      do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat);
      check_result("add_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1);
      release_result();

      do_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, lat);
      check_result("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
      release_result();

      // Backpressure: result held, new request ignored while in DONE
      do_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, lat);
      chk_int("bp_latency", lat, 5);
      held_sum = 64'h2345_6789_ABCD_F001;
      check_result("bp_first", held_sum, 1'b0, 1'b0);
      bus.a        = 64'h1;
      bus.b        = 64'h1;
      bus.cin      = 1'b0;
      bus.sub      = 1'b0;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk64("bp_hold_sum", bus.sum, held_sum);
         chk1("bp_hold_in_ready", bus.in_ready, 1'b0);
         chk1("bp_hold_out_valid", bus.out_valid, 1'b1);
      end
      check_result("bp_after_hold", held_sum, 1'b0, 1'b0);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk1("bp_idle_in_ready", bus.in_ready, 1'b1);
      chk1("bp_idle_out_valid", bus.out_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk1("bp_accepted", bus.in_ready, 1'b0);
      wait_done(lat);
      chk_int("bp_second_latency", lat, 5);
      check_result("bp_second", 64'h2, 1'b0, 1'b0);
      release_result();

      // Reset during the second RUN cycle
      bus.a        = 64'h0001_0001_0001_0001;
      bus.b        = 64'h0002_0002_0002_0002;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk1("mid_rst_out_valid", bus.out_valid, 1'b0);
      chk64("mid_rst_sum", bus.sum, 64'h0);
      chk1("mid_rst_in_ready", bus.in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk1("post_rst_no_valid", bus.out_valid, 1'b0);
      end
      chk1("post_rst_in_ready", bus.in_ready, 1'b1);
      do_op(64'h1, 64'h2, 1'b0, 1'b0, lat);
      chk_int("post_rst_latency", lat, 5);
      check_result("post_rst", 64'h3, 1'b0, 1'b0);
      release_result();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
